// File: rtl/circ_fifo.sv
// Circular FIFO with occupancy counter, threshold flags and sticky errors.
// FWFT selects registered-read (0) or first-word-fall-through (1) output.
module circ_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_enable,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       read_enable,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     counter,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CW'(AF_THRESH));
    assign almost_empty = (cnt <= CW'(AE_THRESH));
    assign counter      = cnt;

    assign wr_ok = write_enable && !full;
    assign rd_ok = read_enable && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= write_data;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error in the same cycle as clr_err must stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && full) overflow <= 1'b1;
            else if (clr_err)         overflow <= 1'b0;
            if (read_enable && empty) underflow <= 1'b1;
            else if (clr_err)         underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Masked when empty so no stale word shows after reset.
            assign read_data  = empty ? '0 : mem[rd_ptr];
            assign read_valid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q;
            logic                  rv_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q <= '0;
                    rv_q <= 1'b0;
                end else begin
                    rv_q <= rd_ok;
                    if (rd_ok) rd_q <= mem[rd_ptr];
                end
            end
            assign read_data  = rd_q;
            assign read_valid = rv_q;
        end
    endgenerate

endmodule

// File: tb/tb_circ_fifo.sv
// Bench for circ_fifo: both read modes side by side against a queue model.
// Directed scenarios first, then a randomized run.
module tb_circ_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_enable = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       read_enable = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rd0, rd1;
    logic       rv0, rv1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [4:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_rd = 8'h00;
    logic       m_rv = 1'b0;

    always #5 clk = ~clk;

    circ_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14),
                .AE_THRESH(2), .FWFT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .read_data(rd0), .read_valid(rv0),
        .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .counter(cnt0), .overflow(ovf0),
        .underflow(unf0), .clr_err(clr_err)
    );

    circ_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14),
                .AE_THRESH(2), .FWFT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .read_data(rd1), .read_valid(rv1),
        .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .counter(cnt1), .overflow(ovf1),
        .underflow(unf1), .clr_err(clr_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, advance the model, settle 1 time unit past the edge.
    task automatic tick(input logic we, input logic [7:0] wd,
                        input logic re, input logic clr);
        logic mf, me, wa, ra;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clr_err      = clr;
        @(posedge clk);
        mf = (q.size() == 16);
        me = (q.size() == 0);
        wa = we && !mf;
        ra = re && !me;
        if (we && mf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (re && me) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        m_rv = ra;
        if (ra) begin
            m_rd = q[0];
            void'(q.pop_front());
        end
        if (wa) q.push_back(wd);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd  = 8'h00;
        m_rv  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cnt0 !== 5'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
        checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin failures++; $display("FAIL rst_flags got=%b exp=1010", {empty0, full0, ae0, af0}); end
        checks++; if ({empty1, full1, ae1, af1} !== 4'b1010) begin failures++; $display("FAIL rst_flags1 got=%b exp=1010", {empty1, full1, ae1, af1}); end
        checks++; if (rd0 !== 8'h00 || rd1 !== 8'h00) begin failures++; $display("FAIL rst_rd got=%h/%h exp=00/00", rd0, rd1); end
        checks++; if ({rv0, rv1, ovf0, unf0} !== 4'b0000) begin failures++; $display("FAIL rst_misc got=%b exp=0000", {rv0, rv1, ovf0, unf0}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            checks++; if (af0 !== (i + 1 >= 14)) begin failures++; $display("FAIL fill_af n=%0d got=%b exp=%b", i + 1, af0, (i + 1 >= 14)); end
            checks++; if (ae0 !== (i + 1 <= 2)) begin failures++; $display("FAIL fill_ae n=%0d got=%b exp=%b", i + 1, ae0, (i + 1 <= 2)); end
        end
        checks++; if (full0 !== 1'b1 || cnt0 !== 5'd16) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/16", full0, cnt0); end
        tick(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (ovf0 !== 1'b1 || cnt0 !== 5'd16) begin failures++; $display("FAIL fill_ovf got=%b/%0d exp=1/16", ovf0, cnt0); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd1 !== 8'(i)) begin failures++; $display("FAIL drain_fwft i=%0d got=%h exp=%h", i, rd1, 8'(i)); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rv0 !== 1'b1 || rd0 !== 8'(i)) begin failures++; $display("FAIL drain_reg i=%0d got=%b/%h exp=1/%h", i, rv0, rd0, 8'(i)); end
        end
        checks++; if (empty0 !== 1'b1 || rv1 !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty0, rv1); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", ovf0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            b = q[0];
            tick(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
            checks++; if (cnt0 !== 5'd5 || cnt1 !== 5'd5) begin failures++; $display("FAIL simul_cnt i=%0d got=%0d/%0d exp=5", i, cnt0, cnt1); end
            checks++; if (rd0 !== b) begin failures++; $display("FAIL simul_data i=%0d got=%h exp=%h", i, rd0, b); end
        end
        for (int i = 0; i < 5; i++) begin
            b = q[0];
            checks++; if (rd1 !== b) begin failures++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, rd1, b); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_boundary();
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (unf0 !== 1'b1 || cnt0 !== 5'd1 || ovf0 !== 1'b0) begin failures++; $display("FAIL bnd_empty got=%b/%0d/%b exp=1/1/0", unf0, cnt0, ovf0); end
        checks++; if (rd1 !== 8'h55 || rv0 !== 1'b0) begin failures++; $display("FAIL bnd_empty_rd got=%h/%b exp=55/0", rd1, rv0); end
        for (int i = 0; i < 15; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (unf0 !== 1'b0 || full0 !== 1'b1) begin failures++; $display("FAIL bnd_clr got=%b/%b exp=0/1", unf0, full0); end
        tick(1'b1, 8'h66, 1'b1, 1'b0);
        checks++; if (ovf0 !== 1'b1 || cnt0 !== 5'd15 || rd0 !== 8'h55) begin failures++; $display("FAIL bnd_full got=%b/%0d/%h exp=1/15/55", ovf0, cnt0, rd0); end
        while (q.size() > 0) tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd0 !== 8'hCE) begin failures++; $display("FAIL bnd_last got=%h exp=ce", rd0); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_modes();
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++; if (rd1 !== 8'h3C || rv1 !== 1'b1 || rv0 !== 1'b0) begin failures++; $display("FAIL mode_fwft got=%h/%b/%b exp=3c/1/0", rd1, rv1, rv0); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd0 !== 8'h3C || rv0 !== 1'b1) begin failures++; $display("FAIL mode_reg got=%h/%b exp=3c/1", rd0, rv0); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (rd0 !== 8'h3C || rv0 !== 1'b0 || rv1 !== 1'b0) begin failures++; $display("FAIL mode_hold got=%h/%b/%b exp=3c/0/0", rd0, rv0, rv1); end
    endtask

    task automatic test_clr_collision();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i * 3), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin failures++; $display("FAIL clr_coll got=%b/%b exp=1/1", ovf0, ovf1); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL clr_after got=%b exp=0", ovf0); end
        while (q.size() > 0) tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hDF, 1'b0, 1'b0);
        checks++; if (cnt0 !== 5'd9 || rd0 !== 8'hD0) begin failures++; $display("FAIL pre_rst got=%0d/%h exp=9/d0", cnt0, rd0); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || rd0 !== 8'h00 || rd1 !== 8'h00) begin failures++; $display("FAIL mid_rst got=%0d/%b/%h/%h exp=0/1/00/00", cnt0, empty0, rd0, rd1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rv1 !== 1'b0 || rd1 !== 8'h00 || cnt1 !== 5'd0) begin failures++; $display("FAIL post_rst got=%b/%h/%0d exp=0/00/0", rv1, rd1, cnt1); end
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        checks++; if (rd1 !== 8'h77 || cnt0 !== 5'd1) begin failures++; $display("FAIL post_wr got=%h/%0d exp=77/1", rd1, cnt0); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd0 !== 8'h77 || rv0 !== 1'b1 || empty0 !== 1'b1) begin failures++; $display("FAIL post_rd got=%h/%b/%b exp=77/1/1", rd0, rv0, empty0); end
    endtask

    task automatic test_random();
        logic we, re, clr;
        int n;
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            we  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 70 : 30));
            re  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 30 : 70));
            clr = ($urandom_range(0, 15) == 0);
            tick(we, 8'($urandom), re, clr);
            n = q.size();
            checks++;
            if (cnt0 !== 5'(n) || cnt1 !== 5'(n) ||
                full0 !== (n == 16) || empty0 !== (n == 0) ||
                af0 !== (n >= 14) || ae0 !== (n <= 2) ||
                full1 !== (n == 16) || empty1 !== (n == 0) ||
                af1 !== (n >= 14) || ae1 !== (n <= 2) ||
                ovf0 !== m_ovf || unf0 !== m_unf ||
                ovf1 !== m_ovf || unf1 !== m_unf ||
                rv0 !== m_rv || rd0 !== m_rd || rv1 !== (n != 0) ||
                (n != 0 && rd1 !== q[0])) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand i=%0d got cnt=%0d ovf=%b unf=%b rv0=%b rd0=%h rd1=%h exp cnt=%0d ovf=%b unf=%b rv0=%b rd0=%h rd1=%h",
                             i, cnt0, ovf0, unf0, rv0, rd0, rd1, n, m_ovf, m_unf, m_rv, m_rd, (n != 0) ? q[0] : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_boundary();
        test_modes();
        test_clr_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
